// File: rtl/prog_mem_ld.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_ld
// Description : Program memory with a built-in streaming loader.
//               After reset the memory is zeroed one word per cycle (CLEAR).
//               A load session (IDLE -> LOAD -> DONE) accepts LD_WIDTH-bit
//               beats, most significant beat first, and assembles them into
//               IR_WIDTH-bit words that are written from address 0 upwards.
//               The CPU fetches with pc and receives ir; ir is forced to 0
//               (NOP) while busy or when pc is outside the memory.
// Option      : PROG_MEM_IR_REG_EN - when defined, ir is registered (one
//               cycle latency from pc); otherwise ir is combinational.
// Ports       : clk       - clock, all state on rising edge
//               res_n     - asynchronous active-low reset
//               pc        - instruction fetch address
//               ir        - fetched instruction
//               busy      - high in CLEAR or LOAD (CPU stall)
//               ld_start  - single-cycle request to start a load session
//               ld_valid  - ld_data valid this cycle
//               ld_data   - loader beat
//               ld_last   - marks the final beat of the session
//               ld_ready  - beat accepted when ld_valid && ld_ready
//               ld_done   - one-cycle pulse at session end
//               ld_err    - sticky session error flag
//               ld_words  - words written in the current/last session
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_ld #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16,
    parameter int CMD_CNT  = 64,
    parameter int LD_WIDTH = 8
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [IR_WIDTH-1:0] ir,
    output logic                busy,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [LD_WIDTH-1:0] ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                ld_done,
    output logic                ld_err,
    output logic [PC_WIDTH:0]   ld_words
);
    localparam int BEATS = IR_WIDTH / LD_WIDTH;
    localparam int AW    = (CMD_CNT > 1) ? $clog2(CMD_CNT) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AW-1:0]     CLR_LAST  = AW'(CMD_CNT - 1);
    localparam logic [BW-1:0]     BEAT_LAST = BW'(BEATS - 1);
    localparam logic [PC_WIDTH:0] WORDS_MAX = (PC_WIDTH + 1)'(CMD_CNT);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AW-1:0]       clr_addr;
    logic [BW-1:0]       beat_cnt;
    logic [IR_WIDTH-1:0] asm_word;
    logic [IR_WIDTH-1:0] new_word;
    logic                accept;
    logic                word_done;
    logic                room;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [IR_WIDTH-1:0] mem_wdata;
    logic [IR_WIDTH-1:0] ir_next;

    // No reset on the array: zeroing is done by the CLEAR sweep.
    logic [IR_WIDTH-1:0] mem [CMD_CNT];

    // Shift the new beat in at the bottom; the oldest beat ends up on top.
    assign new_word  = IR_WIDTH'({asm_word, ld_data});
    assign accept    = ld_valid && (state == LOAD);
    assign word_done = accept && (beat_cnt == BEAT_LAST);
    // ld_words doubles as the write pointer; it saturates at CMD_CNT.
    assign room      = (ld_words < WORDS_MAX);

    assign mem_we    = (state == CLEAR) || (word_done && room);
    assign mem_addr  = (state == CLEAR) ? clr_addr : ld_words[AW-1:0];
    assign mem_wdata = (state == CLEAR) ? '0 : new_word;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_addr == CLR_LAST) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (ld_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
                if (accept && ld_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ld_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            clr_addr <= '0;
            beat_cnt <= '0;
            asm_word <= '0;
            ld_words <= '0;
            ld_err   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                end
                IDLE: begin
                    if (ld_start) begin
                        beat_cnt <= '0;
                        asm_word <= '0;
                        ld_words <= '0;
                        ld_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        asm_word <= new_word;
                        if (word_done) begin
                            beat_cnt <= '0;
                            if (room) begin
                                ld_words <= ld_words + 1'b1;
                            end else begin
                                // Overflow word is dropped; pointer stays put.
                                ld_err <= 1'b1;
                            end
                        end else if (ld_last) begin
                            // Session ends on a partial word: drop it.
                            beat_cnt <= '0;
                            ld_err   <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ir_next = (!busy && ({1'b0, pc} < WORDS_MAX)) ? mem[pc[AW-1:0]] : '0;

`ifdef PROG_MEM_IR_REG_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ir <= '0;
        end else begin
            ir <= ir_next;
        end
    end
`else
    assign ir = ir_next;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_ld.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_mem_ld
// Description : Self-checking bench for prog_mem_ld. Keeps a reference copy
//               of the memory, replays load sessions into it, and compares
//               fetched words through a scoreboard queue plus a small table
//               of fetch vectors. Honours PROG_MEM_IR_REG_EN for ir latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_mem_ld;
    localparam int N = 64;

    logic        clk      = 1'b0;
    logic        res_n    = 1'b1;
    logic [7:0]  pc       = 8'd0;
    logic [15:0] ir;
    logic        busy;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data  = 8'd0;
    logic        ld_last  = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic [8:0]  ld_words;

    always #5 clk = ~clk;

    prog_mem_ld dut (
        .clk      (clk),
        .res_n    (res_n),
        .pc       (pc),
        .ir       (ir),
        .busy     (busy),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .ld_words (ld_words)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model [N];
    logic [15:0] sbq [$];
    logic [7:0]  beat_q [$];
    int          m_words;
    logic        m_err;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] p, input logic [15:0] exp);
        logic [15:0] e;
        pc = p;
        sbq.push_back(exp);
`ifdef PROG_MEM_IR_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        e = sbq.pop_front();
        check($sformatf("ir_pc%0d", p), {16'h0, ir}, {16'h0, e});
    endtask

    task automatic sweep();
        for (int p = 0; p < N; p++) begin
            fetch(8'(p), model[p]);
        end
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 200);
        check(name, n, 64);
        for (int i = 0; i < N; i++) model[i] = 16'h0;
    endtask

    task automatic session(input int nbeats, input bit finish, input bit gaps);
        logic [15:0] asm_m;
        int          cnt;
        asm_m = 16'h0;
        cnt   = 0;
        sync();
        ld_start = 1'b1;
        sync();
        ld_start = 1'b0;
        check("ready_in_load", ld_ready, 1);
        check("words_at_start", ld_words, 0);
        check("err_at_start", ld_err, 0);
        m_words = 0;
        m_err   = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            logic [7:0] d;
            if (gaps && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                sync();
            end
            if (beat_q.size() > 0) d = beat_q.pop_front();
            else                   d = 8'($urandom);
            ld_valid = 1'b1;
            ld_data  = d;
            ld_last  = finish && (i == nbeats - 1);
            ld_start = (i == 2);   // must be ignored while loading
            sync();
            ld_start = 1'b0;
            asm_m = {asm_m[7:0], d};
            cnt++;
            if (cnt == 2) begin
                cnt = 0;
                if (m_words < N) begin
                    model[m_words] = asm_m;
                    m_words++;
                end else begin
                    m_err = 1'b1;
                end
            end else if (finish && i == nbeats - 1) begin
                m_err = 1'b1;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (finish) begin
            check("done_pulse", ld_done, 1);
            check("busy_in_done", busy, 0);
            check("ld_words", ld_words, m_words);
            check("ld_err", ld_err, m_err);
            sync();
            check("done_cleared", ld_done, 0);
            check("busy_idle", busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd0,   16'h4903};
        vecs[1] = '{8'd1,   16'h8A08};
        vecs[2] = '{8'd2,   16'h0000};
        vecs[3] = '{8'd63,  16'h0000};
        vecs[4] = '{8'd64,  16'h0000};
        vecs[5] = '{8'd255, 16'h0000};

        // Reset values
        #2 res_n = 1'b0;
        #1;
        check("rst_busy", busy, 1);
        check("rst_ir", ir, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_done", ld_done, 0);
        check("rst_words", ld_words, 0);
        check("rst_err", ld_err, 0);
        @(negedge clk);
        @(negedge clk);
        #2 res_n = 1'b1;
        wait_clear("clear_cycles");
        sweep();

        // Two-word session with fixed data, then table-driven fetches
        beat_q = '{8'h49, 8'h03, 8'h8A, 8'h08};
        session(4, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].pc, vecs[i].ir);
        end

        // Status holds while idle
        repeat (5) sync();
        check("hold_words", ld_words, 2);
        check("hold_err", ld_err, 0);
        check("idle_ready", ld_ready, 0);

        // Overflow: 65 words into 64 slots
        session(130, 1'b1, 1'b1);
        check("ovf_words", ld_words, 64);
        check("ovf_err", ld_err, 1);
        sweep();

        // Partial final word: word 1 keeps the previous contents
        session(3, 1'b1, 1'b1);
        check("part_words", ld_words, 1);
        check("part_err", ld_err, 1);
        sweep();

        // Fetch latency and out-of-range pc
        sync();
        pc = 8'd1;
        sync();
        check("lat_pc1", ir, model[1]);
        pc = 8'd64;
        #1;
`ifdef PROG_MEM_IR_REG_EN
        check("lat_hold", ir, model[1]);
        sync();
`endif
        check("lat_pc64", ir, 0);

        // Reset in the middle of a load
        pc = 8'd0;
        session(10, 1'b0, 1'b0);
        #2 res_n = 1'b0;
        #1;
        check("midrst_ir", ir, 0);
        check("midrst_busy", busy, 1);
        check("midrst_ready", ld_ready, 0);
        check("midrst_words", ld_words, 0);
        @(negedge clk);
        @(negedge clk);
        #2 res_n = 1'b1;
        wait_clear("midrst_clear_cycles");
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prog_mem_ld.md
PROG_MEM_LD -- requirements
Module: prog_mem_ld

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter width.
REQ-002 SHALL have parameter IR_WIDTH, default 16, instruction word width.
REQ-003 SHALL have parameter CMD_CNT, default 64, number of instruction words (CMD_CNT <= 2**PC_WIDTH).
REQ-004 SHALL have parameter LD_WIDTH, default 8, loader beat width; IR_WIDTH SHALL be an integer multiple of LD_WIDTH, BEATS = IR_WIDTH/LD_WIDTH.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 res_n  input  1  asynchronous active-low reset.
REQ-007 pc  input  PC_WIDTH  instruction fetch address.
REQ-008 ir  output  IR_WIDTH  fetched instruction.
REQ-009 busy  output  1  high in CLEAR or LOAD; CPU stalls while high.
REQ-010 ld_start  input  1  single-cycle request to begin a load session.
REQ-011 ld_valid  input  1  ld_data valid this cycle.
REQ-012 ld_data  input  LD_WIDTH  loader beat, most significant beat of each word first.
REQ-013 ld_last  input  1  qualifies final beat of the session.
REQ-014 ld_ready  output  1  loader accepts a beat when ld_valid && ld_ready.
REQ-015 ld_done  output  1  one-cycle pulse at session end.
REQ-016 ld_err  output  1  sticky session error flag.
REQ-017 ld_words  output  PC_WIDTH+1  count of words written in current/last session.

Function
REQ-018 FSM states SHALL be CLEAR, IDLE, LOAD, DONE.
REQ-019 CLEAR SHALL write 0 to one word per cycle, address 0 up to CMD_CNT-1, then enter IDLE; duration exactly CMD_CNT cycles.
REQ-020 IDLE + ld_start SHALL enter LOAD next cycle with write pointer 0, beat count 0, ld_words 0, ld_err 0; ld_start outside IDLE SHALL be ignored.
REQ-021 ld_ready SHALL be 1 only in LOAD.
REQ-022 Each accepted beat SHALL shift into a word assembly register; on the BEATS-th beat the word SHALL be written to the pointer address the same edge, pointer and ld_words incremented.
REQ-023 Completed word with pointer == CMD_CNT SHALL be discarded and ld_err set; pointer SHALL not wrap.
REQ-024 Accepted beat with ld_last SHALL end the session: LOAD -> DONE; a word completed by that beat is written first.
REQ-025 ld_last on a beat that does not complete a word SHALL discard the partial word and set ld_err.
REQ-026 DONE SHALL last one cycle with ld_done=1, then enter IDLE.
REQ-027 Unwritten words during a session SHALL retain prior contents.
REQ-028 ir SHALL equal word[pc] when busy=0 and pc < CMD_CNT, else 0 (NOP).
REQ-029 busy SHALL be 1 in CLEAR and LOAD, 0 in IDLE and DONE.
REQ-030 ld_err and ld_words SHALL hold their values from session end until next accepted ld_start.

Reset
REQ-031 res_n low SHALL asynchronously force state CLEAR with clear address 0, pointer 0, beat count 0, ld_words 0, ld_err 0, ld_done 0, ld_ready 0, busy 1, ir 0.
REQ-032 Reset mid-LOAD SHALL abandon the session; memory is then fully zeroed by CLEAR.
REQ-033 Memory array SHALL not have an asynchronous reset; zeroing occurs only via CLEAR.

Configuration
REQ-034 With PROG_MEM_IR_REG_EN defined, ir SHALL be registered: value per REQ-028 for the pc of the previous cycle, reset value 0.
REQ-035 Without PROG_MEM_IR_REG_EN, ir SHALL be combinational per REQ-028, zero latency.

Verification
REQ-036 Release reset, defaults -> busy=1 for 64 cycles, then busy=0, ir=0 for pc=0..63.
REQ-037 ld_start, beats 0x49,0x03,0x8A,0x08 with ld_last on 4th -> ld_done pulse, ld_words=2, ld_err=0, pc=0 ir=0x4903, pc=1 ir=0x8A08.
REQ-038 ld_start, 130 beats (65 words), ld_last on 130th -> ld_words=64, ld_err=1, word 63 = 64th word sent.
REQ-039 ld_start, 3 beats, ld_last on 3rd -> ld_words=1, ld_err=1, word 1 unchanged.
REQ-040 Reset asserted after 10 beats of a load -> ir=0 immediately, busy=1 64 cycles, all words 0.
REQ-041 pc=64 or pc=255 after any load -> ir=0; with PROG_MEM_IR_REG_EN, ir changes one cycle after pc.
